rom_read_arbiter: RTL and testbench
===================================

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 4, ROM address width.
REQ-002 SHALL take parameter DATA_W, default 4, ROM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester read request (bit i = requester i).
REQ-006 SHALL have port req_addr0  input  ADDR_W  requester 0 address.
REQ-007 SHALL have port req_addr1  input  ADDR_W  requester 1 address.
REQ-008 SHALL have port req_ready  output  2  per-requester accept strobe, at most one bit set.
REQ-009 SHALL have port rsp_valid  output  1  response data valid.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port rsp_data  output  DATA_W  returned ROM word.
REQ-012 SHALL have port rsp_id  output  1  requester index owning rsp_data.
REQ-013 SHALL have port rom_en  output  1  enable to external synchronous ROM (1-cycle registered read).
REQ-014 SHALL have port rom_addr  output  ADDR_W  address to external ROM.
REQ-015 SHALL have port rom_data  input  DATA_W  ROM output, valid the cycle after rom_en sampled high; undefined otherwise.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE, one transaction in flight.
REQ-017 IDLE: if any req_valid bit set, SHALL assert req_ready combinationally for exactly one granted requester, latch its address and index, and move to ISSUE; else stay IDLE.
REQ-018 Grant SHALL be round-robin: sole requester wins; if both valid, the requester indicated by priority pointer wins.
REQ-019 Priority pointer SHALL point to the requester not granted last, updated at the accept edge.
REQ-020 ISSUE: rom_en SHALL be 1 and rom_addr SHALL equal the latched address for exactly this one cycle; next state CAPTURE.
REQ-021 CAPTURE: SHALL register rom_data into rsp_data and latched index into rsp_id; next state RESP.
REQ-022 RESP: rsp_valid SHALL be 1; rsp_data/rsp_id SHALL be stable until rsp_valid && rsp_ready; on that edge return to IDLE.
REQ-023 rom_en SHALL be 0 in all states except ISSUE; rom_addr SHALL hold latched address (don't-care to ROM) otherwise.
REQ-024 req_ready SHALL be 0 outside IDLE; requests arriving during a transaction SHALL wait (not be dropped) as long as requester holds req_valid.
REQ-025 Latency: accept edge at cycle 0 -> rsp_valid high in cycle 3; minimum throughput 1 read per 4 cycles with rsp_ready tied high.
REQ-026 rom_data SHALL be sampled only in CAPTURE; X on rom_data at other times SHALL not propagate to outputs.
REQ-027 Deasserting req_valid before grant SHALL be legal and cancel that request without side effects.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE, priority pointer 0, rsp_valid 0, rsp_data 0, rsp_id 0, rom_en 0, rom_addr 0; req_ready 0 while rst high.
REQ-029 Reset during ISSUE/CAPTURE/RESP SHALL abandon the in-flight read with no response emitted; pointer returns to 0.

Structure
REQ-030 FSM state encodings and the 2-requester count SHALL live in the shared package/include; ADDR_W/DATA_W stay module parameters.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick2 (inputs valid[1:0], pointer; outputs grant one-hot); the ROM itself is not instantiated inside the block.

Verification (bench ROM model preloaded: mem[2]=4'hE, mem[5]=4'hA, mem[7]=4'h0, mem[12]=4'h4)
REQ-032 Single read: req_valid=01, addr0=2, rsp_ready=1 -> req_ready=01 cycle 0, rom_en=1 addr=2 cycle 1, rsp_valid=1 rsp_data=E rsp_id=0 cycle 3.
REQ-033 Contention: req_valid=11 continuously, addr0=5, addr1=12 after reset -> responses alternate id0/A, id1/4, id0/A, one per 4 cycles.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data=A, rsp_id held constant; no rom_en pulse and no req_ready during stall.
REQ-035 Reset mid-transaction: rst=1 in CAPTURE -> next cycle rsp_valid=0, rom_en=0, state IDLE; pending requester 1 granted only after rst low.
REQ-036 Cancel: req_valid=10 dropped to 00 while transaction for requester 0 in RESP -> no grant to requester 1, FSM idles; rom_en never asserted with X address.
REQ-037 Address 7 returns rsp_data=0 (zero data distinguishable from reset only via rsp_valid).

Source files
------------

// File: rtl/rom_read_arbiter_pkg.sv
// Shared definitions for the two-requester ROM read arbiter:
// FSM state encoding and requester count.
package rom_read_arbiter_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/rom_read_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester wins, on contention the
// requester named by the priority pointer wins. Grant is one-hot or zero.
module rr_pick2
  import rom_read_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic             ptr,
  output logic [N_REQ-1:0] grant
);

  // Select one requester from the valid vector
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (ptr) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates two read requesters onto one external synchronous ROM,
// keeping a single transaction in flight: accept, issue, capture, respond.
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [N_REQ-1:0]  req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  state_t            state_r;
  logic              ptr_r;
  logic              id_r;
  logic [N_REQ-1:0]  grant_s;
  logic [ADDR_W-1:0] sel_addr_s;

  rr_pick2 u_pick (
    .valid (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Accept strobe is only offered while idle and out of reset
  always_comb begin
    req_ready  = 2'b00;
    sel_addr_s = req_addr0;
    if (!rst && (state_r == ST_IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
    if (grant_s[1]) begin
      sel_addr_s = req_addr1;
    end else begin
      sel_addr_s = req_addr0;
    end
  end

  // Transaction FSM; rom_addr doubles as the latched request address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b0;
      id_r      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= {DATA_W{1'b0}};
      rsp_id    <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            id_r     <= grant_s[1];
            ptr_r    <= grant_s[0];
            rom_addr <= sel_addr_s;
            rom_en   <= 1'b1;
            state_r  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rom_en  <= 1'b0;
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_data  <= rom_data;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rom_en    <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed scenarios followed by
// random traffic, compared each cycle against a transaction-phase model.
module tb_rom_read_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [16];

  // Reference model: phase counts cycles since accept (0 = idle)
  int                m_phase;
  logic              m_ptr;
  logic              m_id;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_rid;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; garbage when not enabled so stray sampling shows up
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
    else        rom_data <= 4'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_grant();
    if (rst || m_phase != 0)   return 2'b00;
    if (req_valid == 2'b01)    return 2'b01;
    if (req_valid == 2'b10)    return 2'b10;
    if (req_valid == 2'b11)    return m_ptr ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    logic [1:0] g;
    @(negedge clk);
    g = model_grant();
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("rom_en",    32'(rom_en),    32'(m_phase == 1));
    chk("rom_addr",  32'(rom_addr),  32'(m_addr));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 3));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_id",    32'(rsp_id),    32'(m_rid));
    if (rst) begin
      m_phase = 0; m_ptr = 1'b0; m_id = 1'b0;
      m_addr = '0; m_data = '0; m_rid = 1'b0;
    end else if (m_phase == 0) begin
      if (g != 2'b00) begin
        m_id    = (g == 2'b10);
        m_addr  = m_id ? req_addr1 : req_addr0;
        m_ptr   = ~m_id;
        m_phase = 1;
      end
    end else if (m_phase == 3) begin
      if (rsp_ready) m_phase = 0;
    end else begin
      if (m_phase == 2) begin
        m_data = mem[m_addr];
        m_rid  = m_id;
      end
      m_phase = m_phase + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    mem[2] = 4'hE; mem[5] = 4'hA; mem[7] = 4'h0; mem[12] = 4'h4;
    m_phase = 0; m_ptr = 1'b0; m_id = 1'b0;
    m_addr = '0; m_data = '0; m_rid = 1'b0;
    rst = 1'b1; req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0; rsp_ready = 1'b1;
    do_reset();

    // Single read from requester 0, address 2
    req_valid = 2'b01; req_addr0 = 4'd2;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) step();
    chk("single_data_E", 32'(rsp_data), 32'h0000000E);
    step(); step();

    // Continuous contention alternates requesters
    do_reset();
    req_valid = 2'b11; req_addr0 = 4'd5; req_addr1 = 4'd12;
    for (int i = 0; i < 13; i++) step();

    // Backpressure in RESP with both requests waiting
    rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset during CAPTURE, requester 1 still pending
    do_reset();
    req_valid = 2'b11;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Cancel: requester 1 withdraws while requester 0 is in RESP
    do_reset();
    req_valid = 2'b01; req_addr0 = 4'd7; rsp_ready = 1'b0;
    step();
    req_valid = 2'b10;
    step(); step(); step();
    chk("addr7_zero_valid", 32'(rsp_valid), 32'h1);
    chk("addr7_zero_data",  32'(rsp_data),  32'h0);
    req_valid = 2'b00;
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Random traffic with occasional reset and backpressure
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_addr0 = 4'($urandom);
      req_addr1 = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
